// File: rtl/control_sequencer.sv
// Hardwired control unit for the 8-bit ALU datapath: two-byte fetch, then one or
// two execute steps chosen from the opcode, with a private Z flag for branches.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  SC,
  output logic        Halted,
  output logic        Zflag
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3} sc_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LD  = 4'h1, OP_LDM = 4'h2, OP_ST  = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_INC = 4'h8, OP_DEC = 4'h9, OP_BRA = 4'hA, OP_BEQ = 4'hB,
    OP_BNE = 4'hC, OP_RSD = 4'hD, OP_RSE = 4'hE, OP_HLT = 4'hF
  } op_e;

  sc_e        sc_q, sc_d;
  logic       halted_q, halted_d;
  logic       zflag_q, zflag_d;
  op_e        op;
  logic [1:0] rd, rs;
  logic [3:0] rd_en;
  logic       is_alu, two_step, take_branch;
  logic       unused_ok;

  assign op          = op_e'(IROut[15:12]);
  assign rd          = IROut[11:10];
  assign rs          = IROut[9:8];
  assign rd_en       = 4'b1000 >> rd;
  assign is_alu      = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign two_step    = (op == OP_LDM) || (op == OP_ST);
  assign take_branch = (op == OP_BRA) || ((op == OP_BEQ) && zflag_q) ||
                       ((op == OP_BNE) && !zflag_q);
  // Low flag bits and the immediate go straight to the datapath, not through here.
  assign unused_ok   = &{1'b0, ALUOutFlag[2:0], IROut[7:0]};

  always_comb begin
    sc_d     = sc_q;
    halted_d = halted_q;
    zflag_d  = zflag_q;
    if (!halted_q) begin
      case (sc_q)
        T0: sc_d = T1;
        T1: sc_d = T2;
        T2: begin
          if (is_alu) zflag_d = ALUOutFlag[3];
          if (two_step)            sc_d = T3;
          else if (op == OP_HLT)   halted_d = 1'b1;
          else                     sc_d = T0;
        end
        default: sc_d = T0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sc_q     <= T0;
      halted_q <= 1'b0;
      zflag_q  <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      halted_q <= halted_d;
      zflag_q  <= zflag_d;
    end
  end

  // Reset gates the decode so outputs are idle while Reset is held, not T0.
  always_comb begin
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_FunSel   = '0;
    RF_RSel     = '0;
    RF_TSel     = '0;
    ALU_FunSel  = '0;
    ARF_OutCSel = '0;
    ARF_OutDSel = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = '0;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = '0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = 1'b0;
    if (Reset && !halted_q) begin
      case (sc_q)
        T0, T1: begin
          Mem_CS     = 1'b0;
          IR_Enable  = 1'b1;
          IR_Funsel  = 2'b01;
          IR_LH      = (sc_q == T0);
          ARF_RegSel = 4'b1000;
          ARF_FunSel = 2'b11;
        end
        T2: begin
          case (op)
            OP_LD: begin
              MuxASel   = 2'b10;
              RF_FunSel = 2'b01;
              RF_RSel   = rd_en;
            end
            OP_LDM, OP_ST: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b0100;
              ARF_FunSel = 2'b01;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              RF_OutASel = {1'b0, rd};
              RF_OutBSel = {1'b0, rs};
              case (op)
                OP_ADD:  ALU_FunSel = 4'b0100;
                OP_SUB:  ALU_FunSel = 4'b0101;
                OP_AND:  ALU_FunSel = 4'b0111;
                default: ALU_FunSel = 4'b1000;
              endcase
              RF_FunSel = 2'b01;
              RF_RSel   = rd_en;
            end
            OP_INC, OP_DEC: begin
              RF_FunSel = (op == OP_INC) ? 2'b11 : 2'b10;
              RF_RSel   = rd_en;
            end
            OP_BRA, OP_BEQ, OP_BNE: begin
              if (take_branch) begin
                MuxBSel    = 2'b10;
                ARF_RegSel = 4'b1000;
                ARF_FunSel = 2'b01;
              end
            end
            default: ;
          endcase
        end
        T3: begin
          if (op == OP_LDM) begin
            ARF_OutDSel = 2'b01;
            Mem_CS      = 1'b0;
            MuxASel     = 2'b01;
            RF_FunSel   = 2'b01;
            RF_RSel     = rd_en;
          end else if (op == OP_ST) begin
            ARF_OutDSel = 2'b01;
            RF_OutASel  = {1'b0, rd};
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SC     = sc_q;
  assign Halted = halted_q;
  assign Zflag  = zflag_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed table, hand-written reset and
// halt sequences, and random instruction streams against an instruction-level model.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel, ARF_FunSel, ARF_OutCSel, ARF_OutDSel, IR_Funsel, MuxASel, MuxBSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted, Zflag;
  logic [2:0]  SC;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .SC(SC), .Halted(Halted), .Zflag(Zflag)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] rf_a;
    logic [2:0] rf_b;
    logic [1:0] rf_fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [3:0] alu;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [3:0] arf_reg;
    logic [1:0] arf_fun;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] muxa;
    logic [1:0] muxb;
    logic       muxc;
  } ctrl_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flag;
    ctrl_t       exp_t2;
    logic        exp_z;
  } vec_t;

  ctrl_t act;
  int    passed = 0;
  int    total  = 0;
  int    m_step = 0;
  logic  m_z    = 1'b0;
  logic  m_halt = 1'b0;

  always_comb begin
    act         = '0;
    act.rf_a    = RF_OutASel;
    act.rf_b    = RF_OutBSel;
    act.rf_fun  = RF_FunSel;
    act.rsel    = RF_RSel;
    act.tsel    = RF_TSel;
    act.alu     = ALU_FunSel;
    act.arf_c   = ARF_OutCSel;
    act.arf_d   = ARF_OutDSel;
    act.arf_reg = ARF_RegSel;
    act.arf_fun = ARF_FunSel;
    act.ir_lh   = IR_LH;
    act.ir_en   = IR_Enable;
    act.ir_fun  = IR_Funsel;
    act.mem_wr  = Mem_WR;
    act.mem_cs  = Mem_CS;
    act.muxa    = MuxASel;
    act.muxb    = MuxBSel;
    act.muxc    = MuxCSel;
  end

  function automatic ctrl_t idle_c();
    ctrl_t c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  // Reference behaviour: micro-operations of each instruction at a given step.
  function automatic ctrl_t exp_ctrl(input int step, input logic [15:0] ir, input logic z);
    ctrl_t      c  = idle_c();
    int         op = int'(ir[15:12]);
    logic [1:0] rd = ir[11:10];
    logic [3:0] en = 4'b1000 >> rd;
    if (step < 2) begin
      c.mem_cs = 0; c.ir_en = 1; c.ir_fun = 2'b01; c.ir_lh = (step == 0);
      c.arf_reg = 4'b1000; c.arf_fun = 2'b11;
    end else if (step == 2) begin
      if (op == 1) begin
        c.muxa = 2'b10; c.rf_fun = 2'b01; c.rsel = en;
      end else if (op == 2 || op == 3) begin
        c.muxb = 2'b10; c.arf_reg = 4'b0100; c.arf_fun = 2'b01;
      end else if (op >= 4 && op <= 7) begin
        c.alu  = (op == 4) ? 4'b0100 : (op == 5) ? 4'b0101 : (op == 6) ? 4'b0111 : 4'b1000;
        c.rf_a = {1'b0, rd}; c.rf_b = {1'b0, ir[9:8]};
        c.rf_fun = 2'b01; c.rsel = en;
      end else if (op == 8 || op == 9) begin
        c.rf_fun = (op == 8) ? 2'b11 : 2'b10; c.rsel = en;
      end else if (op == 10 || (op == 11 && z) || (op == 12 && !z)) begin
        c.muxb = 2'b10; c.arf_reg = 4'b1000; c.arf_fun = 2'b01;
      end
    end else if (step == 3) begin
      if (op == 2) begin
        c.arf_d = 2'b01; c.mem_cs = 0; c.muxa = 2'b01; c.rf_fun = 2'b01; c.rsel = en;
      end else if (op == 3) begin
        c.arf_d = 2'b01; c.rf_a = {1'b0, rd}; c.mem_cs = 0; c.mem_wr = 1;
      end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
  endtask

  task automatic check_model(input string nm);
    #1;
    chk({nm, ".sc"}, 64'(SC), 64'(m_step));
    chk({nm, ".halted"}, 64'(Halted), 64'(m_halt));
    chk({nm, ".zflag"}, 64'(Zflag), 64'(m_z));
    chk({nm, ".ctrl"}, 64'(act), m_halt ? 64'(idle_c()) : 64'(exp_ctrl(m_step, IROut, m_z)));
  endtask

  task automatic tick();
    int   op  = int'(IROut[15:12]);
    int   len = (op == 2 || op == 3) ? 4 : 3;
    int   ns  = m_step;
    logic nz  = m_z;
    logic nh  = m_halt;
    if (!m_halt) begin
      if (m_step == 2 && op >= 4 && op <= 7) nz = ALUOutFlag[3];
      if (m_step == 2 && op == 15) nh = 1'b1;
      else ns = (m_step == len - 1) ? 0 : m_step + 1;
    end
    @(posedge Clock); #1;
    m_step = ns; m_z = nz; m_halt = nh;
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic [3:0] flag,
                           output ctrl_t t2, output ctrl_t t3);
    int n = (ir[15:12] == 4'h2 || ir[15:12] == 4'h3) ? 4 : 3;
    IROut = ir; ALUOutFlag = flag;
    t2 = '0; t3 = '0;
    for (int s = 0; s < n; s++) begin
      check_model($sformatf("instr %h T%0d", ir, s));
      if (s == 2) t2 = act;
      if (s == 3) t3 = act;
      tick();
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_z = 1'b0; m_halt = 1'b0;
  endtask

  vec_t  tbl[15];
  ctrl_t t2, t3, e;

  initial begin
    for (int i = 0; i < 15; i++) begin
      tbl[i].flag = 4'b0000; tbl[i].exp_t2 = idle_c(); tbl[i].exp_z = 1'b0;
    end
    tbl[0].ir = 16'h1C5A; tbl[0].exp_t2.muxa = 2'b10; tbl[0].exp_t2.rf_fun = 2'b01;
    tbl[0].exp_t2.rsel = 4'b0001;
    tbl[1].ir = 16'h3430; tbl[1].exp_t2.muxb = 2'b10; tbl[1].exp_t2.arf_reg = 4'b0100;
    tbl[1].exp_t2.arf_fun = 2'b01;
    tbl[2].ir = 16'h5100; tbl[2].flag = 4'b1000; tbl[2].exp_z = 1;
    tbl[2].exp_t2.alu = 4'b0101; tbl[2].exp_t2.rf_b = 3'b001; tbl[2].exp_t2.rf_fun = 2'b01;
    tbl[2].exp_t2.rsel = 4'b1000;
    tbl[3].ir = 16'hB040; tbl[3].exp_z = 1; tbl[3].exp_t2.muxb = 2'b10;
    tbl[3].exp_t2.arf_reg = 4'b1000; tbl[3].exp_t2.arf_fun = 2'b01;
    tbl[4] = tbl[2]; tbl[4].flag = 4'b0000; tbl[4].exp_z = 0;
    tbl[5].ir = 16'hB040;
    tbl[6].ir = 16'h6E00; tbl[6].flag = 4'b1000; tbl[6].exp_z = 1;
    tbl[6].exp_t2.alu = 4'b0111; tbl[6].exp_t2.rf_a = 3'b011; tbl[6].exp_t2.rf_b = 3'b010;
    tbl[6].exp_t2.rf_fun = 2'b01; tbl[6].exp_t2.rsel = 4'b0001;
    tbl[7].ir = 16'h8400; tbl[7].exp_z = 1; tbl[7].exp_t2.rf_fun = 2'b11;
    tbl[7].exp_t2.rsel = 4'b0100;
    tbl[8].ir = 16'hC040; tbl[8].exp_z = 1;
    tbl[9].ir = 16'h9000; tbl[9].flag = 4'b0000; tbl[9].exp_z = 1;
    tbl[9].exp_t2.rf_fun = 2'b10; tbl[9].exp_t2.rsel = 4'b1000;
    tbl[10].ir = 16'hA0FF; tbl[10].exp_z = 1; tbl[10].exp_t2.muxb = 2'b10;
    tbl[10].exp_t2.arf_reg = 4'b1000; tbl[10].exp_t2.arf_fun = 2'b01;
    tbl[11].ir = 16'hD123; tbl[11].exp_z = 1;
    tbl[12].ir = 16'h0000; tbl[12].exp_z = 1;
    tbl[13].ir = 16'h7B00; tbl[13].exp_z = 0;
    tbl[13].exp_t2.alu = 4'b1000; tbl[13].exp_t2.rf_a = 3'b010; tbl[13].exp_t2.rf_b = 3'b011;
    tbl[13].exp_t2.rf_fun = 2'b01; tbl[13].exp_t2.rsel = 4'b0010;
    tbl[14].ir = 16'hC040; tbl[14].exp_t2.muxb = 2'b10;
    tbl[14].exp_t2.arf_reg = 4'b1000; tbl[14].exp_t2.arf_fun = 2'b01;

    Reset = 1'b0; IROut = '0; ALUOutFlag = '0;
    #3;
    chk("reset.sc", 64'(SC), 64'd0);
    chk("reset.ctrl", 64'(act), 64'(idle_c()));
    chk("reset.halted", 64'(Halted), 64'd0);
    chk("reset.zflag", 64'(Zflag), 64'd0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b1; model_reset();

    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].ir, tbl[i].flag, t2, t3);
      chk($sformatf("tbl%0d.t2", i), 64'(t2), 64'(tbl[i].exp_t2));
      chk($sformatf("tbl%0d.z", i), 64'(Zflag), 64'(tbl[i].exp_z));
    end

    // ST T3 drives a memory write from AR with Rd on OutA.
    run_instr(16'h3430, 4'b0000, t2, t3);
    e = idle_c(); e.arf_d = 2'b01; e.rf_a = 3'b001; e.mem_cs = 0; e.mem_wr = 1;
    chk("st.t3", 64'(t3), 64'(e));

    // Reset in the middle of LDM T3.
    IROut = 16'h2C10; ALUOutFlag = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      check_model("ldm_abort.pre");
      tick();
    end
    chk("ldm_abort.at_t3", 64'(SC), 64'd3);
    #2; Reset = 1'b0; #1;
    chk("ldm_abort.sc", 64'(SC), 64'd0);
    chk("ldm_abort.cs", 64'(Mem_CS), 64'd1);
    chk("ldm_abort.rsel", 64'(RF_RSel), 64'd0);
    @(negedge Clock); Reset = 1'b1; model_reset();
    #1;
    chk("refetch.lh0", 64'(IR_LH), 64'd1);
    chk("refetch.sc0", 64'(SC), 64'd0);
    tick();
    check_model("refetch");
    chk("refetch.lh1", 64'(IR_LH), 64'd0);
    for (int g = 0; g < 8 && m_step != 0; g++) begin
      tick();
      check_model("refetch.rest");
    end
    chk("refetch.back_to_t0", 64'(m_step), 64'(SC));

    for (int i = 0; i < 300; i++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      ir[15:12] = 4'($urandom_range(0, 14));
      run_instr(ir, 4'($urandom), t2, t3);
    end

    // Halt, then hold for many cycles until reset.
    IROut = 16'hF000; ALUOutFlag = 4'b1000;
    for (int s = 0; s < 3; s++) begin
      check_model("hlt.run");
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      IROut = 16'($urandom);
      check_model("hlt.hold");
      chk("hlt.cs", 64'(Mem_CS), 64'd1);
      tick();
    end
    chk("hlt.sc", 64'(SC), 64'd2);
    Reset = 1'b0; #1;
    chk("hlt.reset_halted", 64'(Halted), 64'd0);
    chk("hlt.reset_sc", 64'(SC), 64'd0);
    @(negedge Clock); Reset = 1'b1; model_reset();
    IROut = 16'h1000;
    check_model("post_halt");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
